// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchroniser feeding a frame FSM that deserialises,
// checks parity and stop bit, and emits one-cycle result strobes.
module uart_rx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PAR_EN     = 1,
    parameter int unsigned PAR_TYPE   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] P_DATA_out,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stop_err,
    output logic                  busy_flag
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    state_e                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   par_bit_q, par_bit_d;
    logic                   valid_q, valid_d;
    logic                   par_err_q, par_err_d;
    logic                   stop_err_q, stop_err_d;
    logic                   busy_q, busy_d;
    logic                   par_ok;

    assign P_DATA_out = data_q;
    assign data_valid = valid_q;
    assign par_err    = par_err_q;
    assign stop_err   = stop_err_q;
    assign busy_flag  = busy_q;

    // With parity disabled every frame is treated as parity-clean.
    assign par_ok = (PAR_EN == 0) || (par_bit_q == ((^shift_q) ^ (PAR_TYPE != 0)));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        par_bit_d  = par_bit_q;
        valid_d    = 1'b0;
        par_err_d  = 1'b0;
        stop_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d = StData;
                    cnt_d   = '0;
                end
            end
            StData: begin
                // Right shift so the first (LSB) data bit ends up in bit 0.
                shift_d = DATA_WIDTH'({rx_s_q, shift_q} >> 1);
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = (PAR_EN != 0) ? StParity : StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StParity: begin
                par_bit_d = rx_s_q;
                state_d   = StStop;
            end
            StStop: begin
                if (rx_s_q) begin
                    if (par_ok) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        par_err_d = 1'b1;
                    end
                    state_d = StIdle;
                end else begin
                    stop_err_d = 1'b1;
                    par_err_d  = !par_ok;
                    state_d    = StBreak;
                end
            end
            StBreak: begin
                // Wait for the line to return high so a held-low line is not a start bit.
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= StIdle;
            cnt_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            par_bit_q  <= 1'b0;
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_meta_q  <= rx_in;
            rx_s_q     <= rx_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            par_bit_q  <= par_bit_d;
            valid_q    <= valid_d;
            par_err_q  <= par_err_d;
            stop_err_q <= stop_err_d;
            busy_q     <= busy_d;
        end
    end

endmodule
